// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: op codes, FSM states and flag positions.
// Flags are packed {N,Z,C,V}, matching the older combinational ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NEG = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_HOLD = 2'b10
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational result and flags for every single-cycle ALU op.
// MUL is produced by the sequential datapath in alu_pipe, so it yields zero here.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   sum_s;
  logic             carry_s;
  logic             ovf_s;

  // SUB reuses the adder as a + ~b + 1; bit WIDTH of the sum is the carry-out.
  always_comb begin
    if (op[0]) begin
      b_eff_s = ~b;
    end else begin
      b_eff_s = b;
    end
    sum_s = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, op[0]};
  end

  // Op decode with N/Z derived uniformly from the selected result.
  always_comb begin
    result  = {WIDTH{1'b0}};
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result  = sum_s[WIDTH-1:0];
        carry_s = sum_s[WIDTH];
        ovf_s   = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ op[0]) & (a[WIDTH-1] ^ sum_s[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_NEG: begin
        result = {WIDTH{1'b0}} - a;
        ovf_s  = (a == {1'b1, {(WIDTH-1){1'b0}}});
      end
      OP_MUL:  result = {WIDTH{1'b0}};
      default: result = {WIDTH{1'b0}};
    endcase
    flags         = 4'b0000;
    flags[FLAG_N] = result[WIDTH-1];
    flags[FLAG_Z] = (result == {WIDTH{1'b0}});
    flags[FLAG_C] = carry_s;
    flags[FLAG_V] = ovf_s;
  end

endmodule

// File: rtl/alu_pipe.sv
// Valid/ready wrapped ALU: single-cycle ops land in the output registers on accept,
// MUL runs a WIDTH-cycle shift-add before presenting its result.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       ALUFlags
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [3:0]         mul_flags_s;
  logic [WIDTH-1:0]   core_result_s;
  logic [3:0]         core_flags_s;
  logic               accept_s;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (a),
    .b      (b),
    .op     (ALUControl),
    .result (core_result_s),
    .flags  (core_flags_s)
  );

  // in_ready depends only on state and out_ready, never on in_valid.
  always_comb begin
    case (state_r)
      S_IDLE:  in_ready = 1'b1;
      S_HOLD:  in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept_s = in_valid & in_ready;

  // One shift-add step and the flags of the product it would finish with.
  always_comb begin
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
    mul_flags_s         = 4'b0000;
    mul_flags_s[FLAG_N] = acc_next_s[WIDTH-1];
    mul_flags_s[FLAG_Z] = (acc_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
    mul_flags_s[FLAG_V] = |acc_next_s[2*WIDTH-1:WIDTH];
  end

  // FSM, multiply datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= S_IDLE;
      out_valid <= 1'b0;
      Result    <= {WIDTH{1'b0}};
      ALUFlags  <= 4'b0000;
      cnt_r     <= {CW{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      mcand_r   <= {(2*WIDTH){1'b0}};
      mplier_r  <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        S_IDLE, S_HOLD: begin
          if (accept_s && (ALUControl == OP_MUL)) begin
            state_r   <= S_BUSY;
            out_valid <= 1'b0;
            mcand_r   <= {{WIDTH{1'b0}}, a};
            mplier_r  <= b;
            acc_r     <= {(2*WIDTH){1'b0}};
            cnt_r     <= CW'(WIDTH);
          end else if (accept_s) begin
            state_r   <= S_HOLD;
            out_valid <= 1'b1;
            Result    <= core_result_s;
            ALUFlags  <= core_flags_s;
          end else if ((state_r == S_HOLD) && out_ready) begin
            state_r   <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        S_BUSY: begin
          acc_r    <= acc_next_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            state_r   <= S_HOLD;
            out_valid <= 1'b1;
            Result    <= acc_next_s[WIDTH-1:0];
            ALUFlags  <= mul_flags_s;
          end
        end
        default: begin
          state_r   <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and random bench for alu_pipe at WIDTH=8 with a result scoreboard.
module tb_alu_pipe;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] ALUControl;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Result;
  logic [3:0] ALUFlags;

  int tests = 0;
  int fails = 0;
  logic [11:0] sb[$];

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ALUControl(ALUControl), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .ALUFlags(ALUFlags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: {Result, N, Z, C, V}.
  function automatic logic [11:0] model(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op);
    logic [7:0]  r;
    logic        c;
    logic        v;
    logic [8:0]  s;
    logic [15:0] p;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin s = x + y; r = s[7:0]; c = s[8]; v = (x[7] == y[7]) && (r[7] != x[7]); end
      3'd1: begin r = x - y; c = (x >= y); v = (x[7] != y[7]) && (r[7] != x[7]); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: begin p = x * y; r = p[7:0]; v = (p[15:8] != 8'h00); end
      3'd5: r = ($signed(x) < $signed(y)) ? 8'h01 : 8'h00;
      3'd6: r = x ^ y;
      default: begin r = 8'h00 - x; v = (x == 8'h80); end
    endcase
    return {r, r[7], (r == 8'h00), c, v};
  endfunction

  // Scoreboard: retire on out handshake, push on in handshake, drop on reset.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      sb.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        check("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
        if (sb.size() != 0) check("sb_result", {Result, ALUFlags}, sb.pop_front());
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) sb.push_back(model(a, b, ALUControl));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op);
    in_valid = 1'b1; a = x; b = y; ALUControl = op;
  endtask

  task automatic single_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                           input logic [2:0] op, input logic [7:0] er, input logic [3:0] ef);
    drive(x, y, op);
    @(negedge clk) check({tag, "_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_res"}, Result, er);
    check({tag, "_flags"}, ALUFlags, ef);
    tick();
  endtask

  task automatic mul_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] er, input logic [3:0] ef);
    drive(x, y, 3'd4);
    @(negedge clk) check({tag, "_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check({tag, "_busy_valid"}, out_valid, 0);
      check({tag, "_busy_ready"}, in_ready, 0);
    end
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_res"}, Result, er);
    check({tag, "_flags"}, ALUFlags, ef);
    tick();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; ALUControl = 3'd0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_res", Result, 0);
    check("rst_flags", ALUFlags, 0);
    check("rst_ready", in_ready, 1);
    tick();

    // Reset three cycles into a multiply.
    drive(8'h0D, 8'h0B, 3'd4);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    check("midmul_valid", out_valid, 0);
    check("midmul_res", Result, 0);
    check("midmul_flags", ALUFlags, 0);
    check("midmul_ready", in_ready, 1);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk) check("no_stale", out_valid, 0);
    end
    tick();

    // Back-to-back ADD then SUB.
    drive(8'h7F, 8'h01, 3'd0);
    @(negedge clk) check("add_ready", in_ready, 1);
    tick();
    drive(8'h05, 8'h05, 3'd1);
    @(negedge clk);
    check("add_valid", out_valid, 1);
    check("add_res", Result, 8'h80);
    check("add_flags", ALUFlags, 4'b1001);
    check("b2b_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("sub_valid", out_valid, 1);
    check("sub_res", Result, 8'h00);
    check("sub_flags", ALUFlags, 4'b0110);
    tick();

    mul_op("mul_a", 8'h0D, 8'h0B, 8'h8F, 4'b1000);
    mul_op("mul_b", 8'h10, 8'h10, 8'h00, 4'b0101);
    single_op("neg_min", 8'h80, 8'h00, 3'd7, 8'h80, 4'b1001);
    single_op("neg_3", 8'h03, 8'h00, 3'd7, 8'hFD, 4'b1000);
    single_op("slt", 8'hFF, 8'h01, 3'd5, 8'h01, 4'b0000);

    // Backpressure on an XOR, then release together with a new AND.
    out_ready = 1'b0;
    drive(8'hF0, 8'h0F, 3'd6);
    @(negedge clk) check("xor_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_res", Result, 8'hFF);
      check("bp_flags", ALUFlags, 4'b1000);
      check("bp_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    drive(8'hF0, 8'h0F, 3'd2);
    @(negedge clk);
    check("release_ready", in_ready, 1);
    check("release_res_old", Result, 8'hFF);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("and_valid", out_valid, 1);
    check("and_res", Result, 8'h00);
    check("and_flags", ALUFlags, 4'b0100);
    tick();

    // Random ops with valid/ready toggling, checked by the scoreboard.
    for (int i = 0; i < 600; i++) begin
      in_valid   = ($urandom_range(0, 2) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      a          = 8'($urandom);
      b          = 8'($urandom);
      ALUControl = 3'($urandom_range(0, 7));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    check("drain_empty", sb.size(), 0);
    tick(); tick();
    check("drain_idle_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the team's 5-bit combinational ALU. Keeps the same 3-bit operation encoding and the {N,Z,C,V} flag order. Widens the datapath to WIDTH bits, registers results behind a valid/ready interface, and adds a multi-cycle shift-add multiply and a signed set-less-than. It sits between the register-file read stage and the writeback stage of the datapath.

## Interface
- WIDTH, 32, operand/result width; legal range 4..64.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operands and op are presented.
- in_ready  out  1  block accepts the operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ALUControl  in  3  operation select.
- out_valid  out  1  Result and ALUFlags are valid.
- out_ready  in  1  consumer takes the result this cycle.
- Result  out  WIDTH  registered result.
- ALUFlags  out  4  registered {neg, zero, carry, overflow}.

## Operation
- Op encoding, ALUControl:
  - 000 ADD: a+b.
  - 001 SUB: a+~b+1.
  - 010 AND.
  - 011 OR.
  - 100 MUL: low WIDTH bits of unsigned a*b, multi-cycle.
  - 101 SLT: Result = 1 if signed a < signed b, else 0.
  - 110 XOR.
  - 111 NEG: Result = -a.
- Arithmetic: the sum is computed at WIDTH+1 bits; bit WIDTH is the carry-out.
- Flags, all ops:
  - N = Result[WIDTH-1].
  - Z = (Result == 0).
- ADD/SUB:
  - C = sum[WIDTH].
  - V = ~(a[W-1]^b[W-1]^ALUControl[0]) & (a[W-1]^sum[W-1]).
- NEG: C=0; V=1 only when a == 1 followed by WIDTH-1 zeros (most negative value).
- MUL: C=0; V=1 when any bit of the 2*WIDTH-bit product above WIDTH-1 is nonzero.
- AND/OR/XOR/SLT: C=0, V=0.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: multiply in progress; in_ready=0, out_valid=0.
  - HOLD: out_valid=1; in_ready = out_ready.
- Transitions:
  - IDLE or HOLD, on accept (in_valid & in_ready):
    - MUL → BUSY; load the multiplicand, multiplier and zeroed 2*WIDTH accumulator; counter = WIDTH.
    - Any other op → HOLD, with Result/ALUFlags loaded the same edge.
  - BUSY: each cycle, if multiplier[0] is set, accumulator += multiplicand; then shift multiplicand left and multiplier right, and decrement the counter. When the counter reaches 0 (after WIDTH cycles), load Result/ALUFlags and go to HOLD.
  - HOLD with out_ready & ~in_valid → IDLE.
  - HOLD with out_ready & in_valid → accept the new op, as above.
- Result/ALUFlags are held stable while out_valid=1 and out_ready=0.
- Operands are captured on accept; a/b/ALUControl may change freely afterwards.

## Timing
- Reset (synchronous): state=IDLE, out_valid=0, Result=0, ALUFlags=4'b0000, counter=0, accumulator=0. Reset overrides everything, including mid-multiply (BUSY aborts, no output produced) and a pending HOLD result (dropped).
- in_ready is 1 in the cycle immediately after reset is released.
- Single-cycle ops: accept at edge k → out_valid=1 after edge k.
- Throughput is one op per cycle when out_ready is held at 1.
- MUL: accept at edge k → out_valid=1 after edge k+WIDTH. in_ready=0 for WIDTH cycles.
- in_ready is combinational from state and out_ready only; there is no path from in_valid to in_ready.
- out_valid, Result and ALUFlags are driven directly from flops.
- Simultaneous out_ready and in_valid in HOLD: the old result retires and the new one appears the next cycle, with no bubble.

## Structure
- Package alu_pkg holds:
  - localparams for the eight op codes (OP_ADD … OP_NEG);
  - the state enum {S_IDLE, S_BUSY, S_HOLD};
  - flag bit positions (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
- Sub-module alu_core: purely combinational, parametrised by WIDTH. It computes result and flags for every single-cycle op. alu_pipe instantiates it and adds the FSM, operand registers, multiply datapath and output registers.
- The counter width is $clog2(WIDTH+1).

## Test plan
All scenarios use WIDTH=8.
- Reset: assert reset during BUSY (MUL accepted 3 cycles earlier) → next cycle state IDLE, out_valid=0, Result=0x00, ALUFlags=0000, in_ready=1; no stale result ever appears.
- ADD/SUB flags, back-to-back with out_ready=1:
  - 0x7F+0x01 → Result=0x80, ALUFlags=1001.
  - 0x05−0x05 → Result=0x00, ALUFlags=0110.
  - Each result appears one cycle after its accept.
- MUL timing and overflow:
  - 0x0D*0x0B → Result=0x8F, ALUFlags=1000, out_valid exactly 8 cycles after accept, in_ready=0 throughout.
  - 0x10*0x10 → Result=0x00, ALUFlags=0101.
- NEG/SLT:
  - NEG 0x80 → Result=0x80, ALUFlags=1001.
  - NEG 0x03 → Result=0xFD, ALUFlags=1000.
  - SLT a=0xFF, b=0x01 → Result=0x01, ALUFlags=0000.
- Backpressure: hold out_ready=0 for 5 cycles after an XOR 0xF0^0x0F → Result stays 0xFF, ALUFlags stays 1000, in_ready=0. Raising out_ready together with in_valid (AND 0xF0&0x0F) → next cycle Result=0x00, ALUFlags=0100.
- Random: random ops, operands and valid/ready toggling, checked against a reference model. No result is lost or duplicated, and order is preserved.
